// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite manager slice: FSM state encoding and response codes.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite bundle with manager and subordinate views.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport manager (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport subordinate (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_wdt.sv
// Saturating wait counter; expired holds once TIMEOUT_CYCLES-1 wait cycles have elapsed.
module axi4_lite_wdt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)            r_cnt <= '0;
    else if (clr)            r_cnt <= '0;
    else if (en && !expired) r_cnt <= r_cnt + 1'b1;
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/axi4_lite_mgr.sv
// Single-outstanding AXI4-Lite manager: turns a cmd/rsp handshake pair into one
// AXI read or write, with a wait-cycle timeout that forces an SLVERR response.
module axi4_lite_mgr
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi4_if.manager                 m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e                r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_timeout;

  logic w_accept, w_aw_done, w_w_done, w_wdt_en, w_expired, w_done, w_timeout;

  assign w_accept  = cmd_valid && r_cmd_ready;
  // A channel is done once its valid has dropped or its handshake lands this cycle.
  assign w_aw_done = !r_awvalid || m_axi.awready;
  assign w_w_done  = !r_wvalid  || m_axi.wready;
  assign w_wdt_en  = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                     (r_state == RD_REQ) || (r_state == RD_DATA);

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      WR_REQ:  w_done = w_aw_done && w_w_done;
      WR_RESP: w_done = m_axi.bvalid;
      RD_REQ:  w_done = m_axi.arready;
      RD_DATA: w_done = m_axi.rvalid;
      default: w_done = 1'b0;
    endcase
  end

  // A progress handshake on the expiry cycle takes priority over the abort.
  assign w_timeout = w_wdt_en && w_expired && !w_done;

  axi4_lite_wdt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (w_accept),
    .en      (w_wdt_en),
    .expired (w_expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= OKAY;
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= SLVERR;
      r_rsp_timeout <= 1'b1;
      r_state       <= RSP;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= cmd_addr;
            r_wdata       <= cmd_wdata;
            r_wstrb       <= cmd_wstrb;
            r_rsp_timeout <= 1'b0;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= WR_RESP;
          end else begin
            if (r_awvalid && m_axi.awready) r_awvalid <= 1'b0;
            if (r_wvalid && m_axi.wready)   r_wvalid  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= m_axi.bresp;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_axi.rdata;
            r_rsp_resp  <= m_axi.rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;

  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = r_rready;

endmodule

// File: tb/tb_axi4_lite_mgr.sv
// Directed bench for axi4_lite_mgr against a small 8-word AXI4-Lite subordinate model.
module tb_axi4_lite_mgr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready, rsp_valid, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axi       (axi)
  );

  // Subordinate model: readies from bench knobs, responses registered.
  logic          awready_en = 1'b1, wready_en = 1'b1, rvalid_en = 1'b1;
  logic [31:0]   mem [8] = '{default: '0};
  logic          sb_aw_got, sb_w_got, sb_bvalid, sb_ar_pend, sb_rvalid;
  logic [AW-1:0] sb_awaddr, sb_araddr;
  logic [DW-1:0] sb_wdata, sb_rdata;
  logic [3:0]    sb_wstrb;
  int            n_aw = 0, n_w = 0, n_b = 0;

  assign axi.awready = awready_en;
  assign axi.wready  = wready_en;
  assign axi.arready = 1'b1;
  assign axi.bvalid  = sb_bvalid;
  assign axi.bresp   = 2'b00;
  assign axi.rvalid  = sb_rvalid;
  assign axi.rdata   = sb_rdata;
  assign axi.rresp   = 2'b00;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sb_aw_got  <= 1'b0;
      sb_w_got   <= 1'b0;
      sb_bvalid  <= 1'b0;
      sb_ar_pend <= 1'b0;
      sb_rvalid  <= 1'b0;
      sb_rdata   <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        sb_aw_got <= 1'b1; sb_awaddr <= axi.awaddr; n_aw <= n_aw + 1;
      end
      if (axi.wvalid && axi.wready) begin
        sb_w_got <= 1'b1; sb_wdata <= axi.wdata; sb_wstrb <= axi.wstrb; n_w <= n_w + 1;
      end
      if (sb_aw_got && sb_w_got && !sb_bvalid) begin
        if (sb_awaddr < 32)
          for (int b = 0; b < 4; b++)
            if (sb_wstrb[b]) mem[sb_awaddr[4:2]][8*b +: 8] <= sb_wdata[8*b +: 8];
        sb_aw_got <= 1'b0;
        sb_w_got  <= 1'b0;
        sb_bvalid <= 1'b1;
      end
      if (sb_bvalid && axi.bready) begin
        sb_bvalid <= 1'b0; n_b <= n_b + 1;
      end
      if (axi.arvalid && axi.arready) begin
        sb_ar_pend <= 1'b1; sb_araddr <= axi.araddr;
      end
      if (sb_ar_pend && rvalid_en && !sb_rvalid) begin
        sb_rvalid  <= 1'b1;
        sb_ar_pend <= 1'b0;
        sb_rdata   <= (sb_araddr < 32) ? mem[sb_araddr[4:2]] : '0;
      end
      if (sb_rvalid && axi.rready) sb_rvalid <= 1'b0;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Returns on the negedge just after the accepting posedge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    chk("cmd_ready_seen", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin @(negedge aclk); cyc++; end
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cyc, aw0, w0, b0;

    // reset state
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi_vr", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    chk("rst_addr_data", {axi.awaddr, axi.wdata}, 0);
    chk("rst_araddr_strb", {axi.araddr, axi.wstrb}, 0);
    chk("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // write 0x04 = DEADBEEF, then read it back
    aw0 = n_aw; w0 = n_w;
    issue(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(cyc);
    chk("wr_resp", rsp_resp, 2'b00);
    chk("wr_rdata_zero", rsp_rdata, 0);
    chk("wr_timeout", rsp_timeout, 0);
    chk("wr_aw_count", n_aw - aw0, 1);
    chk("wr_w_count", n_w - w0, 1);
    chk("wr_mem", mem[1], 32'hDEAD_BEEF);
    take_rsp();
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("rd_04_data", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_04_resp", rsp_resp, 2'b00);
    take_rsp();

    // unmapped read
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("rd_40_data", rsp_rdata, 0);
    chk("rd_40_resp", rsp_resp, 2'b00);
    chk("rd_40_timeout", rsp_timeout, 0);
    take_rsp();

    // partial strobes: only bytes 0 and 2 land
    issue(1'b1, 32'h10, 32'hAABB_CCDD, 4'h5);
    wait_rsp(cyc);
    take_rsp();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("strb_readback", rsp_rdata, 32'h00BB_00DD);
    take_rsp();

    // timeout with AW and W never ready
    awready_en = 1'b0; wready_en = 1'b0;
    issue(1'b1, 32'h08, 32'h1234_5678, 4'hF);
    wait_rsp(cyc);
    chk("to_latency", cyc, TO);
    chk("to_resp", rsp_resp, 2'b10);
    chk("to_flag", rsp_timeout, 1);
    chk("to_aw_w_b", {axi.awvalid, axi.wvalid, axi.bready}, 0);
    take_rsp();
    awready_en = 1'b1; wready_en = 1'b1;
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    chk("to_cleared_on_accept", rsp_timeout, 0);
    wait_rsp(cyc);
    chk("to_no_write", rsp_rdata, 0);
    chk("to_after_resp", {rsp_resp, rsp_timeout}, 0);
    take_rsp();

    // W completes three cycles ahead of AW
    awready_en = 1'b0; wready_en = 1'b1;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    issue(1'b1, 32'h0C, 32'h1122_3344, 4'hF);
    @(negedge aclk);
    chk("split_w_dropped", axi.wvalid, 0);
    chk("split_aw_held", axi.awvalid, 1);
    repeat (2) @(negedge aclk);
    chk("split_aw_held_late", axi.awvalid, 1);
    awready_en = 1'b1;
    wait_rsp(cyc);
    chk("split_resp", {rsp_resp, rsp_timeout}, 0);
    take_rsp();
    chk("split_aw_count", n_aw - aw0, 1);
    chk("split_w_count", n_w - w0, 1);
    chk("split_b_count", n_b - b0, 1);
    chk("split_mem", mem[3], 32'h1122_3344);

    // response stall: fields hold, no new command accepted
    issue(1'b1, 32'h1C, 32'h5A, 4'hF);
    wait_rsp(cyc);
    take_rsp();
    issue(1'b0, 32'h1C, 32'h0, 4'h0);
    wait_rsp(cyc);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'h5A);
      chk("stall_resp", {rsp_resp, rsp_timeout}, 0);
      chk("stall_cmd_ready", cmd_ready, 0);
      @(negedge aclk);
    end
    take_rsp();

    // reset while waiting in RD_DATA
    rvalid_en = 1'b0;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    @(negedge aclk);
    chk("rst_mid_rready", axi.rready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_ar_r", {axi.arvalid, axi.rready}, 0);
    repeat (3) begin
      @(negedge aclk);
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    aresetn = 1'b1;
    rvalid_en = 1'b1;
    @(negedge aclk);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_no_rsp_after", rsp_valid, 0);
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("recover_rd", rsp_rdata, 32'h1122_3344);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi4_lite_mgr.md
AXI4_LITE_MGR -- requirements
Module: axi4_lite_mgr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum wait cycles per transaction, range 2..65535.
REQ-004 SHALL have port aclk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command accepted.
REQ-008 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH bits: target byte address.
REQ-010 SHALL have port cmd_wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port cmd_wstrb, input, DATA_WIDTH/8 bits: write byte strobes.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response offered.
REQ-013 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-014 SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, 0 for writes.
REQ-015 SHALL have port rsp_resp, output, 2 bits: AXI response code.
REQ-016 SHALL have port rsp_timeout, output, 1 bit: transaction aborted by timeout.
REQ-017 SHALL have port m_axi, axi4_if.manager modport: AXI4-Lite manager side, feeding axi4_lite_sub.

Function
REQ-018 SHALL allow one outstanding transaction; cmd_ready = 1 only in IDLE.
REQ-019 SHALL use states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-020 SHALL, on cmd_valid&&cmd_ready, register addr/data/strb and go to WR_REQ if cmd_write, else RD_REQ.
REQ-021 SHALL in WR_REQ assert awvalid and wvalid together from the first cycle, with awprot = 0; each valid drops the cycle after its own handshake, and W may complete before, with, or after AW.
REQ-022 SHALL leave WR_REQ when both AW and W are done, go to WR_RESP, and hold bready = 1 there.
REQ-023 SHALL on bvalid&&bready capture bresp, go to RSP, and set rsp_rdata = 0.
REQ-024 SHALL in RD_REQ assert arvalid with arprot = 0 until arready, then go to RD_DATA.
REQ-025 SHALL in RD_DATA hold rready = 1 and on rvalid capture rdata/rresp, then go to RSP.
REQ-026 SHALL in RSP hold rsp_valid = 1 with stable fields until rsp_ready, then return to IDLE.
REQ-027 SHALL keep no valid or ready asserted outside its own state, and keep registered outputs stable while stalled.
REQ-028 SHALL clear the wait counter on command accept and increment it each cycle in WR_REQ, WR_RESP, RD_REQ, and RD_DATA; it saturates and never wraps.
REQ-029 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without completion, deassert all AXI valids/readies, go to RSP with rsp_resp = 2'b10 and rsp_timeout = 1 (recovery path only).
REQ-030 SHALL clear rsp_timeout on the next accepted command.
REQ-031 SHALL let a completion handshake occurring on the timeout cycle win, with rsp_timeout = 0.

Reset
REQ-032 SHALL on aresetn low force IDLE with cmd_ready = 0, all AXI valids/readies = 0, awaddr/araddr/wdata/wstrb = 0, rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0, and counter = 0.
REQ-033 SHALL drive cmd_ready = 1 from the first clock edge after reset release.
REQ-034 SHALL, on reset mid-transaction, discard the transaction and issue no response.

Structure
REQ-035 SHALL take the state enum and response constants OKAY = 00, SLVERR = 10 from shared package axi4_lite_pkg.
REQ-036 SHALL implement the wait counter as sub-module axi4_lite_wdt (inputs clr, en; output expired).

Verification
REQ-037 Write 0x04 = 0xDEADBEEF, strb 0xF, to axi4_lite_sub -> one AW and one W handshake, rsp_resp = 00, then read 0x04 returns 0xDEADBEEF.
REQ-038 Read 0x40 (unmapped) -> rsp_rdata = 0, rsp_resp = 00, rsp_timeout = 0.
REQ-039 Stub with awready tied 0, TIMEOUT_CYCLES = 16 -> rsp_valid 16 cycles after accept, rsp_resp = 10, rsp_timeout = 1, awvalid = 0.
REQ-040 wready asserted 3 cycles before awready -> wvalid drops after W handshake, awvalid held, single bresp response.
REQ-041 rsp_ready held 0 for 10 cycles after a read of 0x1C = 0x5A -> rsp fields stable and cmd_ready = 0 throughout.
REQ-042 aresetn low in RD_DATA -> arvalid/rready = 0 immediately, no rsp_valid, cmd_ready = 1 after release.
